// File: rtl/i2c_pkg.sv
// Shared I2C definitions: command codes, FSM state encoding and the
// shift-register preload used by both the master and the slave model.
package i2c_pkg;

  localparam logic [1:0] CMD_START = 2'd0;
  localparam logic [1:0] CMD_STOP  = 2'd1;
  localparam logic [1:0] CMD_WRITE = 2'd2;
  localparam logic [1:0] CMD_READ  = 2'd3;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_START = 2'd1;
  localparam logic [1:0] ST_STOP  = 2'd2;
  localparam logic [1:0] ST_XFER  = 2'd3;

  // Bit 8 of a transfer is the ACK slot.
  localparam logic [3:0] LAST_BIT = 4'd8;

  // 9-bit transmit pattern, MSB first; a 1 releases SDA. A READ releases
  // the data bits and sends ACK (0) unless rdnack asks for NACK (1).
  function automatic logic [8:0] xfer_load(input logic       is_read,
                                           input logic [7:0] tx,
                                           input logic       rdnack);
    return is_read ? {8'hFF, rdnack} : {tx, 1'b1};
  endfunction

endpackage

// File: rtl/i2c_qtick.sv
// Quarter-bit tick generator: reloads on phase start, pauses while a
// released SCL is still held low by a slave.
module i2c_qtick
  import i2c_pkg::*;
#(
  parameter int QDIV = 120
) (
  input  logic clk6x,
  input  logic resetn,
  input  logic load,
  input  logic run,
  input  logic freeze,
  output logic tick
);

  localparam int CW = (QDIV > 1) ? $clog2(QDIV) : 1;
  localparam logic [CW-1:0] RELOAD = CW'(QDIV - 1);

  logic [CW-1:0] cnt;

  assign tick = run && !freeze && (cnt == '0);

  always_ff @(posedge clk6x) begin
    if (!resetn) begin
      cnt <= '0;
    end else if (load || tick) begin
      cnt <= RELOAD;
    end else if (run && !freeze) begin
      cnt <= cnt - 1'b1;
    end
  end

endmodule

// File: rtl/i2c_master.sv
// Single-master I2C engine: START / STOP / byte WRITE / byte READ issued one
// command at a time, each phase split into four quarter-bit steps.
module i2c_master
  import i2c_pkg::*;
#(
  parameter int QDIV = 120
) (
  input  logic       clk6x,
  input  logic       resetn,
  input  logic       I2C_SDA_i,
  output logic       I2C_SDADR0_o,
  input  logic       I2C_SCL_i,
  output logic       I2C_SCLDR0_o,
  input  logic [1:0] cmd_i,
  input  logic       cmd_v_i,
  input  logic [7:0] txbyte_i,
  input  logic       rdnack_i,
  output logic       rdy_o,
  output logic [7:0] rxbyte_o,
  output logic       rxbyte_v_o,
  output logic       ackd_o,
  output logic [1:0] dbg_state_o
);

  // Handshake: a command is taken on the rising edge where cmd_v_i and rdy_o
  // are both 1; cmd_v_i while rdy_o is 0 is dropped, never queued.

  logic [1:0] state;
  logic [1:0] q;
  logic [3:0] bitcnt;
  logic [8:0] shreg;
  logic       is_read;
  logic       sda_dr;
  logic       scl_dr;
  logic       busy;
  logic       accept;
  logic       freeze;
  logic       tick;
  logic [8:0] xfer_init;

  assign busy        = (state != ST_IDLE);
  assign accept      = !busy && cmd_v_i;
  assign freeze      = busy && !scl_dr && !I2C_SCL_i;
  assign xfer_init   = xfer_load(cmd_i == CMD_READ, txbyte_i, rdnack_i);
  assign rdy_o       = !busy;
  assign dbg_state_o = state;

  assign I2C_SDADR0_o = sda_dr;
  assign I2C_SCLDR0_o = scl_dr;

  i2c_qtick #(
    .QDIV(QDIV)
  ) u_qtick (
    .clk6x (clk6x),
    .resetn(resetn),
    .load  (accept),
    .run   (busy),
    .freeze(freeze),
    .tick  (tick)
  );

  always_ff @(posedge clk6x) begin
    if (!resetn) begin
      state      <= ST_IDLE;
      q          <= 2'd0;
      bitcnt     <= 4'd0;
      shreg      <= 9'd0;
      is_read    <= 1'b0;
      sda_dr     <= 1'b0;
      scl_dr     <= 1'b0;
      rxbyte_o   <= 8'h00;
      rxbyte_v_o <= 1'b0;
      ackd_o     <= 1'b0;
    end else begin
      rxbyte_v_o <= 1'b0;
      if (accept) begin
        q      <= 2'd0;
        bitcnt <= 4'd0;
        case (cmd_i)
          CMD_START: begin
            state  <= ST_START;
            sda_dr <= 1'b0;
          end
          CMD_STOP: begin
            state  <= ST_STOP;
            sda_dr <= 1'b1;
          end
          default: begin
            state   <= ST_XFER;
            is_read <= (cmd_i == CMD_READ);
            shreg   <= xfer_init;
            sda_dr  <= !xfer_init[8];
          end
        endcase
      end else if (tick) begin
        q <= q + 2'd1;
        case (state)
          ST_START: begin
            case (q)
              2'd0:    scl_dr <= 1'b0;
              2'd1:    sda_dr <= 1'b1;
              2'd2:    scl_dr <= 1'b1;
              default: state  <= ST_IDLE;
            endcase
          end
          ST_STOP: begin
            case (q)
              2'd0:    scl_dr <= 1'b0;
              2'd1:    sda_dr <= 1'b0;
              2'd3:    state  <= ST_IDLE;
              default: ;
            endcase
          end
          ST_XFER: begin
            case (q)
              2'd1: scl_dr <= 1'b0;
              // Sample lands in bit 0 so that after 9 bits the data byte
              // sits in [8:1] and the ACK slot in [0].
              2'd2: shreg  <= {shreg[7:0], I2C_SDA_i};
              2'd3: begin
                scl_dr <= 1'b1;
                if (bitcnt == LAST_BIT) begin
                  state <= ST_IDLE;
                  if (is_read) begin
                    rxbyte_o   <= shreg[8:1];
                    rxbyte_v_o <= 1'b1;
                  end else begin
                    ackd_o <= !shreg[0];
                  end
                end else begin
                  bitcnt <= bitcnt + 4'd1;
                  sda_dr <= !shreg[8];
                end
              end
              default: ;
            endcase
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: doc/i2c_master.md
I2C_MASTER -- requirements
Module: i2c_master

Interface
REQ-001 SHALL have parameter QDIV, default 120, meaning the number of clk6x cycles per quarter SCL bit period (120 gives 100 kHz SCL at 48 MHz).
REQ-002 SHALL have port clk6x, input, 1 bit: the 48 MHz system clock; all logic is on its rising edge.
REQ-003 SHALL have port resetn, input, 1 bit: synchronous, active-low reset.
REQ-004 SHALL have port I2C_SDA_i, input, 1 bit: sampled SDA line.
REQ-005 SHALL have port I2C_SDADR0_o, output, 1 bit: 1 pulls SDA low; 0 releases it.
REQ-006 SHALL have port I2C_SCL_i, input, 1 bit: sampled SCL line, used to detect clock stretching.
REQ-007 SHALL have port I2C_SCLDR0_o, output, 1 bit: 1 pulls SCL low; 0 releases it.
REQ-008 SHALL have port cmd_i, input, 2 bits: 0=START, 1=STOP, 2=WRITE, 3=READ.
REQ-009 SHALL have port cmd_v_i, input, 1 bit: command valid; accepted only while rdy_o=1.
REQ-010 SHALL have port txbyte_i, input, 8 bits: byte for WRITE, sampled on the cycle the command is accepted.
REQ-011 SHALL have port rdnack_i, input, 1 bit: for READ, 1 sends NACK after the byte (last byte), 0 sends ACK.
REQ-012 SHALL have port rdy_o, output, 1 bit: idle and able to accept a command.
REQ-013 SHALL have port rxbyte_o, output, 8 bits: last received byte; held until the next READ completes.
REQ-014 SHALL have port rxbyte_v_o, output, 1 bit: 1-cycle pulse when rxbyte_o is updated.
REQ-015 SHALL have port ackd_o, output, 1 bit: the slave ACK (SDA low) seen on the last WRITE; updated when the WRITE completes.

Function
REQ-016 SHALL implement the FSM IDLE -> {START, STOP, XFER}, with each of START, STOP and XFER returning to IDLE; rdy_o=1 only in IDLE.
REQ-017 SHALL advance phases only on quarter ticks, produced by a counter reloaded with QDIV-1 at every phase start.
REQ-018 START SHALL release SDA (Q0), then release SCL (Q1), then pull SDA low (Q2), then pull SCL low (Q3).
REQ-019 START SHALL serve as a repeated START when issued after a transfer.
REQ-020 STOP SHALL pull SDA low (Q0), then release SCL (Q1), then release SDA (Q2), then wait one quarter (Q3).
REQ-021 XFER SHALL shift 9 bits, MSB first; the 9th bit is the ACK slot.
REQ-022 For WRITE, XFER SHALL drive the 8 data bits and release SDA in the ACK slot.
REQ-023 For READ, XFER SHALL release SDA for the 8 data bits and drive rdnack_i inverted into the ACK slot (ACK pulls SDA low).
REQ-024 Per bit, Q0 SHALL keep SCL low and set SDA; Q1 SHALL hold; Q2 SHALL release SCL; Q3 SHALL sample SDA, then pull SCL low.
REQ-025 Clock stretching: after SCL is released, the quarter counter SHALL freeze while I2C_SCL_i=0 and resume once it reads 1.
REQ-026 For READ, rxbyte_o SHALL update and rxbyte_v_o SHALL pulse for 1 cycle on the same edge the FSM enters IDLE.
REQ-027 For WRITE, ackd_o SHALL equal the inverted SDA sample from the 9th-bit Q3, updated on entry to IDLE.
REQ-028 rdy_o SHALL go low on the cycle after acceptance.
REQ-029 cmd_v_i while rdy_o=0 SHALL be ignored, with no queuing.
REQ-030 Between commands the bus SHALL stay as last driven: SCL low after START/XFER, both lines released after STOP.
REQ-031 The bit counter SHALL be 4 bits, with the terminal value 8 ending XFER.

Reset
REQ-032 While resetn=0, the block SHALL set state IDLE, I2C_SDADR0_o=0, I2C_SCLDR0_o=0, rdy_o=1, rxbyte_o=8'h00, rxbyte_v_o=0, ackd_o=0, and clear all counters.
REQ-033 Reset mid-transfer SHALL release both lines on the next edge, and SHALL NOT generate a STOP.

Structure
REQ-034 The command codes and the FSM state encoding SHALL reside in a shared package, i2c_pkg, which i2c_slave also uses.
REQ-035 The quarter-tick divider with stretch freeze SHALL be a sub-module, i2c_qtick.
REQ-036 All other logic SHALL be flat.

Verification
REQ-037 Bench SHALL check: START then STOP with QDIV=4 -> SDA falls while SCL is high, SCL falls 4 cycles later; STOP -> SDA rises while SCL is high; both lines end released.
REQ-038 Bench SHALL check: WRITE 8'hA5 with the slave model ACKing -> SDA bit sequence 1,0,1,0,0,1,0,1 sampled on SCL rising edges, and ackd_o=1.
REQ-039 Bench SHALL check: WRITE 8'h3C with no slave ACK -> ackd_o=0 and rdy_o=1 after 36 quarters.
REQ-040 Bench SHALL check: READ with the slave driving 8'h5A and rdnack_i=1 -> rxbyte_o=8'h5A, a single rxbyte_v_o pulse, and SDA released in the 9th bit.
REQ-041 Bench SHALL check: the slave holds SCL low for 50 cycles in bit 3 of a WRITE -> the transfer lengthens by exactly 50 cycles and the data is intact.
REQ-042 Bench SHALL check: resetn=0 asserted mid-READ -> both DR0 outputs are 0 on the next edge, rdy_o=1, and no rxbyte_v_o pulse.
